// File: rtl/frame_mem_pkg.sv
// Shared types and constants for the frame buffer memory responder.
package frame_mem_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    REFRESH = 1'b1
  } state_t;

  // Active-low request and active-high status levels
  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Counter width that can hold 0..max(a,b)-1
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/frame_mem_resp_if.sv
// Request/response bus between the frame buffer and its memory responder.
interface frame_mem_resp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_rdy;
  logic                  rd_rdy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_rdy, rd_rdy, rd_data, rd_data_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_rdy, rd_rdy, rd_data, rd_data_valid
  );
endinterface

// File: rtl/frame_mem_rd_pipe.sv
// Fixed-latency delay line carrying read valid + data to the response port.
module frame_mem_rd_pipe #(
  parameter int RD_LATENCY = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [RD_LATENCY:1]                 r_vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] r_dat_pipe;

  // Valid shift register; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      for (int i = 2; i <= RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // Data shift register; no reset, qualified by the valid bits
  always_ff @(posedge clk) begin
    r_dat_pipe[1] <= i_data;
    for (int i = 2; i <= RD_LATENCY; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
  end

  // Data is forced to zero when not valid so the port reads 0 out of reset
  assign o_vld  = r_vld_pipe[RD_LATENCY];
  assign o_data = o_vld ? r_dat_pipe[RD_LATENCY] : '0;

endmodule

// File: rtl/frame_mem_resp.sv
// Single-port memory responder: array, refresh FSM, write/read arbitration.
module frame_mem_resp
  import frame_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 3,
  parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY     = 3,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_LEN    = 4
) (
  input  logic             clk,
  input  logic             reset,
  frame_mem_resp_if.slave  io_bus
);

  localparam int CW = cnt_width(REFRESH_PERIOD, REFRESH_LEN);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                r_state;
  logic [CW-1:0]         r_ref_cnt;
  logic                  r_pri;       // 0: write wins contention, 1: read wins
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_wr_req, w_rd_req;
  logic                  w_wr_rdy, w_rd_rdy;
  logic                  w_wr_acc, w_rd_acc;
  logic                  w_wr_in, w_rd_in;
  logic [IW-1:0]         w_wr_idx, w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_wr_req = (io_bus.wr_en == ASSERT_L);
  assign w_rd_req = (io_bus.rd_en == ASSERT_L);

  // Ready: stalled in refresh, otherwise idle-ready unless both sides contend
  always_comb begin
    w_wr_rdy = DEASSERT_H;
    w_rd_rdy = DEASSERT_H;
    if (r_state == RUN) begin
      if (w_wr_req && w_rd_req) begin
        w_wr_rdy = ~r_pri;
        w_rd_rdy = r_pri;
      end else begin
        w_wr_rdy = ASSERT_H;
        w_rd_rdy = ASSERT_H;
      end
    end
  end

  assign w_wr_acc = w_wr_req & w_wr_rdy;
  assign w_rd_acc = w_rd_req & w_rd_rdy;

  // Out-of-range addresses are acknowledged but never touch the array
  assign w_wr_in  = ({1'b0, io_bus.wr_addr} < DEPTH_L);
  assign w_rd_in  = ({1'b0, io_bus.rd_addr} < DEPTH_L);
  assign w_wr_idx = io_bus.wr_addr[IW-1:0];
  assign w_rd_idx = io_bus.rd_addr[IW-1:0];

  // Refresh FSM and priority token
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_ref_cnt <= '0;
      r_pri     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_ref_cnt == CW'(REFRESH_PERIOD-1)) begin
            r_state   <= REFRESH;
            r_ref_cnt <= '0;
          end else begin
            r_ref_cnt <= r_ref_cnt + CW'(1);
          end
        end
        REFRESH: begin
          if (r_ref_cnt == CW'(REFRESH_LEN-1)) begin
            r_state   <= RUN;
            r_ref_cnt <= '0;
          end else begin
            r_ref_cnt <= r_ref_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= RUN;
          r_ref_cnt <= '0;
        end
      endcase
      // Alternate winners only when both sides actually contended
      if (w_wr_req && w_rd_req && (w_wr_acc || w_rd_acc)) r_pri <= ~r_pri;
    end
  end

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_wr_in) r_mem[w_wr_idx] <= io_bus.wr_data;
  end

  // Array is read in the acceptance cycle, then delayed to the fixed latency
  assign w_rd_word = w_rd_in ? r_mem[w_rd_idx] : '0;

  frame_mem_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_vld  (w_rd_acc),
    .i_data (w_rd_word),
    .o_vld  (io_bus.rd_data_valid),
    .o_data (io_bus.rd_data)
  );

  assign io_bus.wr_rdy = w_wr_rdy;
  assign io_bus.rd_rdy = w_rd_rdy;

endmodule

// File: tb/tb_frame_mem_resp.sv
// Scoreboard bench for frame_mem_resp (small refresh period, 6-word array).
module tb_frame_mem_resp;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_mem_resp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  frame_mem_resp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .MEM_DEPTH(6),
    .RD_LATENCY(3), .REFRESH_PERIOD(8), .REFRESH_LEN(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc;
  int   n_cmp, n_fail;

  // Cycle index; 0 is the first cycle after reset release
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic wl, input logic rl, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [31:0] wd);
    bus.wr_en   = wl;
    bus.rd_en   = rl;
    bus.wr_addr = wa;
    bus.rd_addr = ra;
    bus.wr_data = wd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 3'd0, 3'd0, 32'h0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cycle with fixed inputs and expected ready levels
  task automatic step(input logic wl, input logic rl, input logic [2:0] wa,
                      input logic [2:0] ra, input logic [31:0] wd,
                      input logic ew, input logic er, input logic [31:0] rexp);
    drive(wl, rl, wa, ra, wd);
    @(negedge clk);
    chk("wr_rdy", 32'(bus.wr_rdy), 32'(ew));
    chk("rd_rdy", 32'(bus.rd_rdy), 32'(er));
    if (!reset && !rl && bus.rd_rdy) q.push_back('{rexp, cyc + 3});
    @(posedge clk); #1;
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    drive(1'b0, 1'b1, a, 3'd0, d);
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge clk);
      acc = bus.wr_rdy;
      @(posedge clk); #1;
    end
    chk("wr_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic do_rd(input logic [2:0] a, input logic [31:0] exp);
    logic acc;
    acc = 1'b0;
    drive(1'b1, 1'b0, 3'd0, a, 32'h0);
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge clk);
      acc = bus.rd_rdy;
      if (acc) q.push_back('{exp, cyc + 3});
      @(posedge clk); #1;
    end
    chk("rd_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle();

    // Monitor: every valid must match the oldest expectation, on its cycle
    fork
      forever begin
        @(negedge clk);
        if (!reset && bus.rd_data_valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid cyc=%0d got=%h want=none", cyc, bus.rd_data);
          end else begin
            mon_e = q.pop_front();
            chk("rd_data", bus.rd_data, mon_e.d);
            chk("rd_cycle", 32'(cyc), 32'(mon_e.c));
          end
        end
      end
    join_none

    // Reset values, first write/read, refresh stall at cycles 8..10
    do_reset(2);
    chk("rst_valid", 32'(bus.rd_data_valid), 32'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("rst_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    step(1'b0, 1'b1, 3'd2, 3'd0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 3'd0, 3'd2, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    for (int i = 2; i <= 6; i++)
      step(1'b0, 1'b1, 3'd3, 3'd0, 32'h33333333, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 3'd0, 3'd3, 32'h0, 1'b1, 1'b1, 32'h33333333);
    for (int i = 8; i <= 11; i++)
      step(1'b0, 1'b1, 3'd3, 3'd0, 32'h33333333, i == 11, i == 11, 32'h0);
    idle();
    wait_cyc(4);
    chk("drained_1", 32'(q.size()), 32'd0);

    // Contention from reset: W,R,W,R,W,R; each read sees the preceding write
    do_reset(2);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 3'd4, 3'd4, 32'(32'h40 + i), (i % 2) == 0, (i % 2) == 1,
           32'(32'h40 + i - 1));

    // Streaming writes/reads; addrs 6,7 are beyond the 6-word array
    for (int i = 0; i < 8; i++) do_wr(3'(i), 32'(32'h11111111 * i));
    for (int i = 0; i < 8; i++) do_rd(3'(i), (i < 6) ? 32'(32'h11111111 * i) : 32'h0);
    do_wr(3'd7, 32'hAA);
    do_rd(3'd7, 32'h0);
    do_wr(3'd5, 32'h5555AAAA);
    do_rd(3'd5, 32'h5555AAAA);
    idle();
    wait_cyc(8);
    chk("drained_2", 32'(q.size()), 32'd0);

    // Reset with reads in flight; priority token must restart on write
    do_reset(2);
    step(1'b0, 1'b0, 3'd1, 3'd1, 32'h1234, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, 1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 3'd0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    chk("post_rst_valid", 32'(bus.rd_data_valid), 32'd0);
    step(1'b0, 1'b0, 3'd1, 3'd1, 32'h5678, 1'b1, 1'b0, 32'h0);
    idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.rd_data_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("drained_3", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
